// File: rtl/ghost_move_scheduler.sv
`default_nettype none
// ============================================================================
// ghost_move_scheduler - shares one GhostDirection unit across all ghosts each
// frame, applies clamped moves, and flags catches and frame overruns.
// Revision: 1.0
// ============================================================================
module ghost_move_scheduler #(
    parameter int NUM_GHOSTS = 4,
    parameter int STEP       = 1,
    parameter int SETTLE     = 2,
    parameter int HOME_X     = 304,
    parameter int HOME_Y     = 240,
    parameter int MAX_X      = 639,
    parameter int MAX_Y      = 479
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    frame_clk,
    input  logic                    Over,
    input  logic                    Restart,
    input  logic [9:0]              PacmanX,
    input  logic [9:0]              PacmanY,
    input  logic [3:0]              DirMovement,
    output logic [9:0]              DirGhostX,
    output logic [9:0]              DirGhostY,
    output logic [10*NUM_GHOSTS-1:0] GhostXs,
    output logic [10*NUM_GHOSTS-1:0] GhostYs,
    output logic [4*NUM_GHOSTS-1:0]  GhostDirs,
    output logic                    Busy,
    output logic                    RoundDone,
    output logic                    Caught,
    output logic                    Overrun
);

    localparam int          IDX_W     = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam logic [10:0] c_step    = 11'(STEP);
    localparam logic [10:0] c_max_x   = 11'(MAX_X);
    localparam logic [10:0] c_max_y   = 11'(MAX_Y);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_cnt;
    logic [9:0]       r_gx   [NUM_GHOSTS];
    logic [9:0]       r_gy   [NUM_GHOSTS];
    logic [3:0]       r_gdir [NUM_GHOSTS];
    logic [9:0]       r_dir_x, r_dir_y;
    logic             r_busy, r_round_done, r_caught, r_overrun;
    logic             r_fsync1, r_fsync2, r_fsync3;

    logic             w_frame_rise;
    logic             w_last;
    logic             w_hit;
    logic [9:0]       w_new_x, w_new_y;

    assign w_frame_rise = r_fsync2 & ~r_fsync3;
    assign w_last       = (r_idx == IDX_W'(NUM_GHOSTS - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fsync1 <= 1'b0;
            r_fsync2 <= 1'b0;
            r_fsync3 <= 1'b0;
        end else begin
            r_fsync1 <= frame_clk;
            r_fsync2 <= r_fsync1;
            r_fsync3 <= r_fsync2;
        end
    end

    // Bounds are checked in 11 bits so a move never wraps the 10-bit position.
    always_comb begin
        w_new_x = r_gx[r_idx];
        w_new_y = r_gy[r_idx];
        case (DirMovement)
            4'b0001: if ({1'b0, r_gx[r_idx]} >= c_step)
                         w_new_x = r_gx[r_idx] - 10'(STEP);
            4'b0010: if (({1'b0, r_gx[r_idx]} + c_step) <= c_max_x)
                         w_new_x = r_gx[r_idx] + 10'(STEP);
            4'b0100: if ({1'b0, r_gy[r_idx]} >= c_step)
                         w_new_y = r_gy[r_idx] - 10'(STEP);
            4'b1000: if (({1'b0, r_gy[r_idx]} + c_step) <= c_max_y)
                         w_new_y = r_gy[r_idx] + 10'(STEP);
            default: ;
        endcase
    end

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            if (r_gx[i] == PacmanX && r_gy[i] == PacmanY)
                w_hit = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_round_done <= 1'b0;
            r_caught     <= 1'b0;
            r_overrun    <= 1'b0;
            r_dir_x      <= 10'(HOME_X);
            r_dir_y      <= 10'(HOME_Y);
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                r_gx[i]   <= 10'(HOME_X + 16 * i);
                r_gy[i]   <= 10'(HOME_Y);
                r_gdir[i] <= 4'b0000;
            end
        end else if (Restart) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_round_done <= 1'b0;
            r_caught     <= 1'b0;
            r_overrun    <= 1'b0;
            r_dir_x      <= 10'(HOME_X);
            r_dir_y      <= 10'(HOME_Y);
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                r_gx[i]   <= 10'(HOME_X + 16 * i);
                r_gy[i]   <= 10'(HOME_Y);
                r_gdir[i] <= 4'b0000;
            end
        end else begin
            r_round_done <= 1'b0;
            r_dir_x      <= r_gx[r_idx];
            r_dir_y      <= r_gy[r_idx];
            if (w_frame_rise && r_state != S_IDLE)
                r_overrun <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_frame_rise && !Over) begin
                        r_state <= S_SETUP;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SETUP: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'(SETTLE - 1))
                        r_state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    r_gdir[r_idx] <= DirMovement;
                    r_gx[r_idx]   <= w_new_x;
                    r_gy[r_idx]   <= w_new_y;
                    if (w_last) begin
                        r_state      <= S_DONE;
                        r_round_done <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_cnt   <= '0;
                        r_state <= S_SETUP;
                    end
                end
                S_DONE: begin
                    r_caught <= r_caught | w_hit;
                    r_idx    <= '0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_pack
            assign GhostXs[10*g +: 10]  = r_gx[g];
            assign GhostYs[10*g +: 10]  = r_gy[g];
            assign GhostDirs[4*g +: 4]  = r_gdir[g];
        end
    endgenerate

    assign DirGhostX = r_dir_x;
    assign DirGhostY = r_dir_y;
    assign Busy      = r_busy;
    assign RoundDone = r_round_done;
    assign Caught    = r_caught;
    assign Overrun   = r_overrun;

endmodule
`default_nettype wire
